// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory port.
// slave = arbiter side, master = requesters plus memory model side.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                    m0_req,    m1_req;
  logic                    m0_we,     m1_we;
  logic [ADDR_WIDTH-1:0]   m0_addr,   m1_addr;
  logic [DATA_WIDTH-1:0]   m0_wdata,  m1_wdata;
  logic [DATA_WIDTH/8-1:0] m0_be,     m1_be;
  logic                    m0_gnt,    m1_gnt;
  logic                    m0_rvalid, m1_rvalid;
  logic [DATA_WIDTH-1:0]   m0_rdata,  m1_rdata;
  logic                    mem_en, mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory, one outstanding read of MEM_LATENCY cycles.
// Define DATA_MEM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic                clk,
  input logic                rst_n,
  data_mem_arbiter_if.slave  bus
);
  localparam int CW = 2;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
`ifdef DATA_MEM_ARB_RR_EN
  logic          last_gnt_q, last_gnt_d;
`endif

  logic rv_cycle, eligible, granted, win, win_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
`ifdef DATA_MEM_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  always_comb begin
    rv_cycle = (state_q == WAIT) && (cnt_q == '0);
    eligible = (state_q == IDLE) || rv_cycle;
    granted  = eligible && (bus.m0_req || bus.m1_req);
`ifdef DATA_MEM_ARB_RR_EN
    // last_gnt resets to 1, so the first contended grant after reset goes to port 0
    if (bus.m0_req && bus.m1_req) win = ~last_gnt_q;
    else                          win = bus.m1_req;
`else
    win = ~bus.m0_req;
`endif
    win_we = win ? bus.m1_we : bus.m0_we;

    bus.m0_gnt    = granted && !win;
    bus.m1_gnt    = granted &&  win;
    bus.mem_en    = granted;
    bus.mem_we    = granted && win_we;
    bus.mem_addr  = granted ? (win ? bus.m1_addr  : bus.m0_addr)  : '0;
    bus.mem_wdata = granted ? (win ? bus.m1_wdata : bus.m0_wdata) : '0;
    bus.mem_be    = granted ? (win ? bus.m1_be    : bus.m0_be)    : '0;

    bus.m0_rvalid = rv_cycle && !owner_q;
    bus.m1_rvalid = rv_cycle &&  owner_q;
    bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
    bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
    bus.busy      = (state_q == WAIT);

    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
`ifdef DATA_MEM_ARB_RR_EN
    last_gnt_d = granted ? win : last_gnt_q;
`endif
    // a read granted in the rvalid cycle reloads the counter instead of going idle
    if (granted && !win_we) begin
      state_d = WAIT;
      cnt_d   = CW'(MEM_LATENCY - 1);
      owner_d = win;
    end else if (rv_cycle) begin
      state_d = IDLE;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 1'b1;
    end
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter sharing the single-port data memory between the CPU load/store path (port 0) and the debug/program-loader path (port 1). It accepts one access per grant, drives the memory port, tracks a single outstanding read for the fixed memory latency, and returns read data to the owning requester. It sits between `data_memory` and its two requesters; the CPU stalls on `m0_req && !m0_gnt`.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, address width
- `MEM_LATENCY`, 1, cycles from issue to `mem_rdata` valid; legal range 1..4
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mN_req`  in  1  request, N = 0,1; held until granted
- `mN_we`  in  1  1 = write, 0 = read
- `mN_addr`  in  ADDR_WIDTH  byte address
- `mN_wdata`  in  DATA_WIDTH  write data
- `mN_be`  in  DATA_WIDTH/8  byte enables
- `mN_gnt`  out  1  access accepted this cycle
- `mN_rvalid`  out  1  read data valid this cycle
- `mN_rdata`  out  DATA_WIDTH  read data, 0 when `mN_rvalid` low
- `mem_en`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`, `mem_wdata`, `mem_be`  out  as above  muxed from granted port
- `mem_rdata`  in  DATA_WIDTH  memory read data
- `busy`  out  1  read outstanding

## Operation
- States: IDLE, WAIT. Reset -> IDLE, `last_gnt` = 1, counter = 0.
- Grant eligibility: state IDLE, or WAIT in the cycle the counter reaches 0 (rvalid cycle).
- When eligible and any `mN_req` high: pick winner, assert `mN_gnt` and `mem_en` combinationally in the same cycle; `mem_*` carry the winner's fields; loser's `gnt` = 0.
- Write grant: completes that cycle; no `rvalid`; state stays/returns IDLE.
- Read grant: latch owner, counter = MEM_LATENCY-1, go WAIT.
- WAIT: counter decrements each cycle; no grants while counter ≠ 0; `busy` = 1.
- Rvalid cycle (WAIT, counter = 0): owner's `rvalid` = 1, `rdata` = `mem_rdata` (pass-through); a new grant may issue in this same cycle (read -> stay WAIT with reloaded counter; write or none -> IDLE).
- Requester must hold `req`/`we`/`addr`/`wdata`/`be` stable until `gnt`; dropping `req` before `gnt` is a legal cancel.
- No requests: all outputs 0 except state-driven `busy`.

## Timing
- Reset values: every `gnt`, `rvalid`, `rdata`, `mem_*` output and `busy` = 0.
- Read: issue cycle T -> `rvalid` at T+MEM_LATENCY. Back-to-back reads: one per MEM_LATENCY cycles.
- Writes: one per cycle when idle.
- Simultaneous requests: resolved per Configuration; the losing request waits, never dropped.
- `rst_n` asserted mid-read: outstanding read discarded, no `rvalid` after release, arbitration restarts from port 0 first.
- `busy` deasserts in the cycle following the rvalid cycle unless a new read was granted in it.

## Configuration
- `DATA_MEM_ARB_RR_EN` defined: round-robin. On contention, grant the port ≠ `last_gnt`; `last_gnt` updates on every grant. Uncontended requests granted immediately.
- Not defined: fixed priority, port 0 always wins; `last_gnt` unused. Port 1 may starve under continuous port 0 traffic (accepted for normal CPU run, loader used only while CPU halted).

## Test plan
- Reset release, no requests -> all outputs 0 for 10 cycles, `busy` = 0.
- MEM_LATENCY=2, m0 read addr 0x10, memory returns 0xDEADBEEF -> `m0_gnt` at T, `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF at T+2, `m1_rvalid`=0 throughout.
- m0 write 0x20/0x12345678/be=0xF, then m1 write same cycle after -> two consecutive single-cycle grants, `mem_we`=1 both cycles, correct addr/data each.
- Both ports continuous reads, MEM_LATENCY=1, RR_EN defined -> grants alternate m0,m1,m0,m1; RR_EN undefined -> m0 every grant, `m1_gnt` never high.
- m0 read granted, m1 read requested during WAIT (MEM_LATENCY=3) -> `m1_gnt` exactly in m0's rvalid cycle, `m1_rvalid` 3 cycles later.
- `rst_n` low one cycle after m1 read grant (MEM_LATENCY=3) -> no `m1_rvalid` ever; next contended request after release granted to m0.
